// File: rtl/valu_pkg.sv
// valu_pkg: shared state encoding, ALU opcode values and timing constants
// for the vector ALU sequencer.
package valu_pkg;

  // Sequencer states, one per phase of the per-element walk
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // ALU opcodes; the sequencer forwards these without checking them
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  // Clock cycles spent on each vector element (RD_A, RD_B, EXEC, WB)
  localparam int CYCLES_PER_ELEM = 4;

endpackage

// File: rtl/valu_sequencer.sv
// valu_sequencer: accepts one vector command, then for every element reads
// operand A and operand B through the single read port, presents them to
// the combinational ALU, and writes the result back at dst+i. Also drives
// the GPIO observation flags.
module valu_sequencer
  import valu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 6
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // command front-end
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic              cmd_abort,
  // operand register file read port
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  // ALU interface
  output logic              alu_valid,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  // register file write port
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  // status and observation flags
  output logic              busy,
  output logic              done,
  output logic              flag_alu_rst,
  output logic              flag_operand,
  output logic [3:0]        flag_operation
);

  state_t state;
  state_t state_next;

  // latched command fields
  logic [3:0]        op_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;

  // element index and per-element pipeline registers
  logic [LEN_W-1:0]  idx;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] res;

  logic              accept;
  logic              last_elem;
  logic [ADDR_W-1:0] idx_addr;

  // A command is taken only while idle; abort never blocks acceptance
  assign accept    = (state == ST_IDLE) && cmd_valid;
  // Index folded to address width so base+index wraps modulo the RF size
  assign idx_addr  = ADDR_W'(idx);
  assign last_elem = (idx == (len_q - LEN_W'(1)));

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every busy state but not IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = (cmd_len == '0) ? ST_DONE : ST_RD_A;
        end
      end
      ST_RD_A: state_next = ST_RD_B;
      ST_RD_B: state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = last_elem ? ST_DONE : ST_RD_A;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (cmd_abort && (state != ST_IDLE)) begin
      state_next = ST_IDLE;
    end
  end

  // Command latch, element index and operand/result capture
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      op_q    <= '0;
      len_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      idx     <= '0;
      opa     <= '0;
      res     <= '0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        len_q   <= cmd_len;
        src_a_q <= cmd_src_a;
        src_b_q <= cmd_src_b;
        dst_q   <= cmd_dst;
        idx     <= '0;
      end
      if (state == ST_RD_B) begin
        opa <= rf_rd_data;
      end
      if (state == ST_EXEC) begin
        res <= alu_result;
      end
      if ((state == ST_WB) && (state_next == ST_RD_A)) begin
        idx <= idx + LEN_W'(1);
      end
    end
  end

  // Moore outputs decoded from the current state, idle values zero
  always_comb begin
    cmd_ready    = 1'b0;
    rf_rd_en     = 1'b0;
    rf_rd_addr   = '0;
    alu_valid    = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    rf_wr_en     = 1'b0;
    rf_wr_addr   = '0;
    rf_wr_data   = '0;
    done         = 1'b0;
    flag_alu_rst = 1'b0;
    flag_operand = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready    = 1'b1;
        flag_alu_rst = 1'b1;
      end
      ST_RD_A: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = src_a_q + idx_addr;
      end
      ST_RD_B: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = src_b_q + idx_addr;
      end
      ST_EXEC: begin
        alu_valid    = 1'b1;
        alu_a        = opa;
        alu_b        = rf_rd_data;
        flag_operand = 1'b1;
      end
      ST_WB: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = dst_q + idx_addr;
        rf_wr_data = res;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign busy           = (state != ST_IDLE);
  assign alu_op         = op_q;
  assign flag_operation = op_q;

endmodule

// File: tb/tb_valu_sequencer.sv
// tb_valu_sequencer: drives vector commands into valu_sequencer, models the
// register file and ALU around it, and compares the resulting register file,
// address sequences and timing against a sequential reference model.
module tb_valu_sequencer;
  import valu_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int LEN_W   = 6;
  localparam int RF_SIZE = 1 << ADDR_W;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic [ADDR_W-1:0] cmd_dst;
  logic              cmd_abort;
  logic              rf_rd_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              alu_valid;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              busy;
  logic              done;
  logic              flag_alu_rst;
  logic              flag_operand;
  logic [3:0]        flag_operation;

  // preload port into the register file model
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  logic [DATA_W-1:0] rf       [RF_SIZE];
  logic [DATA_W-1:0] model_rf [RF_SIZE];

  int errors = 0;
  int checks = 0;

  // observations from the last command
  int obs_done_cyc;
  int obs_ready_cyc;
  int obs_ndone;
  int obs_nwr;
  bit gate_ok;
  bit flags_ok;
  int rd_addrs[$];
  int wr_addrs[$];
  int exp_rd[$];
  int exp_wr[$];

  typedef struct {
    logic [3:0] op;
    int         len;
    int         src_a;
    int         src_b;
    int         dst;
    int         exp_done;
  } vec_t;

  vec_t vecs[6];

  valu_sequencer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_len       (cmd_len),
    .cmd_src_a     (cmd_src_a),
    .cmd_src_b     (cmd_src_b),
    .cmd_dst       (cmd_dst),
    .cmd_abort     (cmd_abort),
    .rf_rd_en      (rf_rd_en),
    .rf_rd_addr    (rf_rd_addr),
    .rf_rd_data    (rf_rd_data),
    .alu_valid     (alu_valid),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data),
    .busy          (busy),
    .done          (done),
    .flag_alu_rst  (flag_alu_rst),
    .flag_operand  (flag_operand),
    .flag_operation(flag_operation)
  );

  // 10 ns clock
  always #5 wb_clk_i = ~wb_clk_i;

  // Arithmetic meaning of each opcode, shared by the ALU stand-in and the model
  function automatic logic [DATA_W-1:0] aluRef(input logic [3:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_MUL:  return a * b;
      default: return '0;
    endcase
  endfunction

  // Combinational ALU stand-in
  always_comb alu_result = aluRef(alu_op, alu_a, alu_b);

  // Register file stand-in: one-cycle read latency, synchronous write, preload
  always @(posedge wb_clk_i) begin
    if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];
    if (load_en) rf[load_addr] <= load_data;
    else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input bit ok, input int actual,
                           input int expected);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 1);
    checkOutput({tag, ".flag_alu_rst"}, 32'(flag_alu_rst), 1);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    checkOutput({tag, ".done"}, 32'(done), 0);
    checkOutput({tag, ".rf_rd_en"}, 32'(rf_rd_en), 0);
    checkOutput({tag, ".rf_rd_addr"}, 32'(rf_rd_addr), 0);
    checkOutput({tag, ".rf_wr_en"}, 32'(rf_wr_en), 0);
    checkOutput({tag, ".rf_wr_addr"}, 32'(rf_wr_addr), 0);
    checkOutput({tag, ".rf_wr_data"}, rf_wr_data, 0);
    checkOutput({tag, ".alu_valid"}, 32'(alu_valid), 0);
    checkOutput({tag, ".alu_a"}, alu_a, 0);
    checkOutput({tag, ".alu_b"}, alu_b, 0);
    checkOutput({tag, ".alu_op"}, 32'(alu_op), 0);
    checkOutput({tag, ".flag_operand"}, 32'(flag_operand), 0);
    checkOutput({tag, ".flag_operation"}, 32'(flag_operation), 0);
  endtask

  // Fill both the register file and the model with the same contents
  task automatic loadRf(input bit ramp);
    for (int k = 0; k < RF_SIZE; k++) begin
      logic [DATA_W-1:0] d;
      if (ramp && k < 8) d = DATA_W'(k);
      else if (ramp && k < 16) d = DATA_W'(10 * (k - 8));
      else d = $urandom;
      @(negedge wb_clk_i);
      load_en   = 1'b1;
      load_addr = ADDR_W'(k);
      load_data = d;
      model_rf[k] = d;
    end
    @(negedge wb_clk_i);
    load_en = 1'b0;
  endtask

  // Sequential element-by-element semantics; only the first 'limit' results land
  task automatic modelRun(input logic [3:0] op, input int len, input int sa,
                          input int sb, input int dst, input int limit);
    exp_rd.delete();
    exp_wr.delete();
    for (int k = 0; k < len; k++) begin
      int ra, rb, wa;
      ra = (sa + k) % RF_SIZE;
      rb = (sb + k) % RF_SIZE;
      wa = (dst + k) % RF_SIZE;
      exp_rd.push_back(ra);
      exp_rd.push_back(rb);
      if (k < limit) begin
        model_rf[wa] = aluRef(op, model_rf[ra], model_rf[rb]);
        exp_wr.push_back(wa);
      end
    end
  endtask

  // Issue one command and watch it; optional abort or reset at a given cycle
  task automatic applyStimulus(input logic [3:0] op, input int len, input int sa,
                               input int sb, input int dst, input int abort_cyc,
                               input int rst_cyc);
    int guard;
    bit in_rst;
    guard = 0;
    in_rst = 1'b0;
    rd_addrs.delete();
    wr_addrs.delete();
    obs_done_cyc  = -1;
    obs_ready_cyc = -1;
    obs_ndone     = 0;
    obs_nwr       = 0;
    gate_ok       = 1'b1;
    flags_ok      = 1'b1;
    @(negedge wb_clk_i);
    while (!cmd_ready && guard < 300) begin
      @(negedge wb_clk_i);
      guard++;
    end
    checkOutput("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_src_a = ADDR_W'(sa);
    cmd_src_b = ADDR_W'(sb);
    cmd_dst   = ADDR_W'(dst);
    for (int cyc = 1; cyc <= 4 * len + 8; cyc++) begin
      @(negedge wb_clk_i);
      if (rf_rd_en) rd_addrs.push_back(int'(rf_rd_addr));
      else if (rf_rd_addr != 0) gate_ok = 1'b0;
      if (rf_wr_en) begin
        wr_addrs.push_back(int'(rf_wr_addr));
        obs_nwr++;
      end else if (rf_wr_addr != 0 || rf_wr_data != 0) gate_ok = 1'b0;
      if (alu_valid) begin
        if (!flag_operand || alu_op != op || flag_operation != op) flags_ok = 1'b0;
      end else if (alu_a != 0 || alu_b != 0 || flag_operand) gate_ok = 1'b0;
      if (busy == cmd_ready || flag_alu_rst != cmd_ready) flags_ok = 1'b0;
      if (done) begin
        obs_ndone++;
        if (obs_done_cyc < 0) obs_done_cyc = cyc;
      end
      if (cmd_ready && obs_ready_cyc < 0) obs_ready_cyc = cyc;
      cmd_valid = 1'b0;
      cmd_abort = 1'b0;
      if (in_rst) begin
        wb_rst_i = 1'b0;
        in_rst   = 1'b0;
      end
      if (cyc == abort_cyc) cmd_abort = 1'b1;
      if (cyc == rst_cyc) begin
        wb_rst_i = 1'b1;
        in_rst   = 1'b1;
        #1;
        checkResetOutputs("mid_cmd_reset");
      end
    end
  endtask

  task automatic compareRf(input string name);
    int bad;
    bad = -1;
    for (int k = 0; k < RF_SIZE; k++) begin
      if (rf[k] !== model_rf[k] && bad < 0) bad = k;
    end
    if (bad >= 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: rf[%0d] got %0h, expected %0h", name, bad, rf[bad],
               model_rf[bad]);
    end else begin
      checkFlag(name, 1'b1, 0, 0);
    end
  endtask

  task automatic compareQueue(input string name, input int act[$], input int exp[$]);
    int bad;
    bad = -1;
    for (int k = 0; k < exp.size(); k++) begin
      if (k >= act.size()) begin
        if (bad < 0) bad = k;
      end else if (act[k] != exp[k] && bad < 0) bad = k;
    end
    if (act.size() != exp.size() && bad < 0) bad = exp.size();
    if (bad >= 0) begin
      checkFlag(name, 1'b0, (bad < act.size()) ? act[bad] : -1,
                (bad < exp.size()) ? exp[bad] : -1);
    end else begin
      checkFlag(name, 1'b1, 0, 0);
    end
  endtask

  task automatic checkRun(input int exp_done, input int exp_ready, input int exp_writes,
                          input bit full_reads);
    checkOutput("done_cycle", 32'(obs_done_cyc), 32'(exp_done));
    checkOutput("done_pulses", 32'(obs_ndone), (exp_done < 0) ? 0 : 1);
    checkOutput("ready_cycle", 32'(obs_ready_cyc), 32'(exp_ready));
    checkOutput("write_count", 32'(obs_nwr), 32'(exp_writes));
    compareQueue("write_addrs", wr_addrs, exp_wr);
    if (full_reads) compareQueue("read_addrs", rd_addrs, exp_rd);
    checkFlag("output_gating", gate_ok, 0, 1);
    checkFlag("flags", flags_ok, 0, 1);
    compareRf("rf_contents");
  endtask

  initial begin
    bit idle_ok;
    vecs[0] = '{OP_ADD, 4, 0, 8, 16, 17};
    vecs[1] = '{OP_XOR, 3, 30, 2, 31, 13};
    vecs[2] = '{OP_OR, 0, 5, 6, 7, 1};
    vecs[3] = '{OP_SUB, 1, 3, 9, 20, 5};
    vecs[4] = '{OP_MUL, 2, 1, 9, 24, 9};
    vecs[5] = '{OP_SLL, 2, 8, 1, 26, 9};

    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    cmd_src_a = '0;
    cmd_src_b = '0;
    cmd_dst   = '0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;

    // reset state and a quiet idle period
    repeat (3) @(negedge wb_clk_i);
    checkResetOutputs("reset");
    wb_rst_i = 1'b0;
    idle_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge wb_clk_i);
      if (!cmd_ready || !flag_alu_rst || busy || rf_rd_en || rf_wr_en || done)
        idle_ok = 1'b0;
    end
    checkFlag("idle_100_cycles", idle_ok, 0, 1);

    // directed table
    loadRf(1'b1);
    for (int i = 0; i < 6; i++) begin
      modelRun(vecs[i].op, vecs[i].len, vecs[i].src_a, vecs[i].src_b, vecs[i].dst,
               vecs[i].len);
      applyStimulus(vecs[i].op, vecs[i].len, vecs[i].src_a, vecs[i].src_b, vecs[i].dst,
                    0, 0);
      checkRun(vecs[i].exp_done, vecs[i].exp_done + 1, vecs[i].len, 1'b1);
      if (i == 0) begin
        checkOutput("add_rf16", rf[16], 0);
        checkOutput("add_rf17", rf[17], 11);
        checkOutput("add_rf18", rf[18], 22);
        checkOutput("add_rf19", rf[19], 33);
      end
    end

    // abort during the second element's EXEC
    modelRun(OP_ADD, 4, 0, 8, 12, 1);
    applyStimulus(OP_ADD, 4, 0, 8, 12, 7, 0);
    checkRun(-1, 8, 1, 1'b0);
    modelRun(OP_AND, 2, 3, 10, 14, 2);
    applyStimulus(OP_AND, 2, 3, 10, 14, 0, 0);
    checkRun(9, 10, 2, 1'b1);

    // reset while in RD_B of the first element
    modelRun(OP_ADD, 3, 4, 12, 20, 0);
    applyStimulus(OP_ADD, 3, 4, 12, 20, 0, 2);
    checkRun(-1, 3, 0, 1'b0);
    modelRun(OP_XOR, 2, 20, 4, 28, 2);
    applyStimulus(OP_XOR, 2, 20, 4, 28, 0, 0);
    checkRun(9, 10, 2, 1'b1);

    // randomized commands
    loadRf(1'b0);
    for (int r = 0; r < 20; r++) begin
      logic [3:0] op;
      int len, sa, sb, dst, ed;
      op  = 4'($urandom_range(0, 7));
      len = $urandom_range(0, 10);
      sa  = $urandom_range(0, RF_SIZE - 1);
      sb  = $urandom_range(0, RF_SIZE - 1);
      dst = $urandom_range(0, RF_SIZE - 1);
      ed  = (len == 0) ? 1 : 4 * len + 1;
      modelRun(op, len, sa, sb, dst, len);
      applyStimulus(op, len, sa, sb, dst, 0, 0);
      checkRun(ed, ed + 1, len, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
